brcomp_iter: RTL

Parametrised, multi-cycle branch comparator for RV32I-class cores. It compares two WIDTH-bit operands MSB-first, CHUNK bits per cycle, and resolves equal, less-than (signed or unsigned) and the branch-taken decision from funct3. Valid/ready handshakes sit on both the request and response sides. It sits between the register-file read stage and the PC-select logic in multi-cycle or area-constrained core variants, replacing the single-cycle comparator.

---
 rtl/brcomp_iter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/brcomp_iter.sv
// brcomp_iter: iterative MSB-first branch comparator, CHUNK bits per cycle, valid/ready on both sides.
// Signed compares flip both MSBs at capture so the datapath is purely an unsigned compare.
module brcomp_iter #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic [2:0]       funct3_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             br_equal_o,
    output logic             br_less_o,
    output logic             br_taken_o,
    output logic             illegal_o
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       rst_sync_q;
    logic             rst_n;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       f3_q, f3_d;
    logic [KW-1:0]    k_q, k_d;
    logic             diff_q, diff_d, lt_q, lt_d;
    logic             eq_q, eq_d, less_q, less_d, taken_q, taken_d, ill_q, ill_d;
    logic [CHUNK-1:0] ca, cb;
    logic             differ, last, has_diff, lt_fin, decided, taken_fin;
    logic [WIDTH-1:0] sign_flip;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync_q <= '0;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            k_q     <= '0;
            diff_q  <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            less_q  <= 1'b0;
            taken_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f3_q    <= f3_d;
            k_q     <= k_d;
            diff_q  <= diff_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            less_q  <= less_d;
            taken_q <= taken_d;
            ill_q   <= ill_d;
        end
    end

    // Operands shift left each cycle, so the current chunk is always the top one.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        f3_d      = f3_q;
        k_d       = k_q;
        diff_d    = diff_q;
        lt_d      = lt_q;
        eq_d      = eq_q;
        less_d    = less_q;
        taken_d   = taken_q;
        ill_d     = ill_q;
        sign_flip = {~funct3_i[1], {(WIDTH-1){1'b0}}};
        ca        = a_q[WIDTH-1 -: CHUNK];
        cb        = b_q[WIDTH-1 -: CHUNK];
        differ    = ca != cb;
        last      = k_q == KW'(N - 1);
        has_diff  = diff_q | differ;
        lt_fin    = diff_q ? lt_q : (differ & (ca < cb));
        decided   = last | (EARLY_EXIT & differ);
        taken_fin = f3_q[2] ? (lt_fin ^ f3_q[0]) : (~f3_q[1] & (~has_diff ^ f3_q[0]));
        unique case (state_q)
            IDLE: if (req_valid_i && req_ready_o) begin
                a_d     = rs1_i ^ sign_flip;
                b_d     = rs2_i ^ sign_flip;
                f3_d    = funct3_i;
                k_d     = '0;
                diff_d  = 1'b0;
                lt_d    = 1'b0;
                state_d = BUSY;
            end
            BUSY: if (decided) begin
                eq_d    = ~has_diff;
                less_d  = lt_fin;
                taken_d = taken_fin;
                ill_d   = f3_q[2:1] == 2'b01;
                state_d = DONE;
            end else begin
                a_d    = a_q << CHUNK;
                b_d    = b_q << CHUNK;
                k_d    = k_q + 1'b1;
                diff_d = has_diff;
                lt_d   = lt_fin;
            end
            DONE: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o = (state_q == IDLE) & rst_n;
    assign rsp_valid_o = state_q == DONE;
    assign br_equal_o  = eq_q;
    assign br_less_o   = less_q;
    assign br_taken_o  = taken_q;
    assign illegal_o   = ill_q;
endmodule
